// File: rtl/simon_key_scheduler_if.sv
// Round-key stream bundle between the SIMON key scheduler and its consumer.
// Master drives the key and valid; slave returns ready.
interface simon_key_scheduler_if #(
  parameter int N = 32
);
  logic         rk_valid;
  logic         rk_ready;
  logic [N-1:0] rk_out;
  logic [6:0]   rk_index;
  logic         rk_last;

  modport master (
    output rk_valid, rk_out, rk_index, rk_last,
    input  rk_ready
  );

  modport slave (
    input  rk_valid, rk_out, rk_index, rk_last,
    output rk_ready
  );
endinterface

// File: rtl/simon_key_scheduler.sv
// Single-pass SIMON key schedule with an M-word sliding window.
// Optional SIMON_KS_REPLAY_EN adds rk_replay and a shadow copy of the key.
module simon_key_scheduler #(
  parameter int N = 32,
  parameter int M = 4,
  parameter int T = 44
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*M-1:0] key_in,
  input  logic           key_load,
`ifdef SIMON_KS_REPLAY_EN
  input  logic           rk_replay,
`endif
  output logic           busy,
  output logic           done,
  simon_key_scheduler_if.master rk
);

  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 =
    62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 =
    62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 =
    62'b11010001111001101011011000100000010111000011001010010011101111;

  localparam logic [61:0] ZSEQ =
    (N == 16)              ? Z0 :
    (N == 24 && M == 3)    ? Z0 :
    (N == 24)              ? Z1 :
    (N == 32 && M == 3)    ? Z2 :
    (N >= 48 && M == 2)    ? Z2 :
    (N == 64 && M == 4)    ? Z4 : Z3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [M-1:0][N-1:0] win;
  logic [6:0]          count;
  logic [5:0]          zptr;

  logic           hs;
  logic           last;
  logic           restart;
  logic           replay;
  logic [N*M-1:0] src;
  logic           zbit;
  logic [N-1:0]   t0;
  logic [N-1:0]   t1;
  logic [N-1:0]   nw;

`ifdef SIMON_KS_REPLAY_EN
  logic [N*M-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (key_load)
      shadow <= key_in;
  end

  assign replay = rk_replay & ~key_load
                & (state != S_RUN);
  assign src    = key_load ? key_in : shadow;
`else
  assign replay = 1'b0;
  assign src    = key_in;
`endif

  assign restart = key_load | replay;
  assign last    = (count == 7'(T - 1));
  assign hs      = (state == S_RUN) & rk.rk_ready;
  assign zbit    = ZSEQ[6'd61 - zptr];

  always_comb begin
    t0 = {win[M-1][2:0], win[M-1][N-1:3]};
    if (M == 4)
      t0 = t0 ^ win[1];
    t1 = t0 ^ {t0[0], t0[N-1:1]};
    nw = ~win[0] ^ t1 ^ N'(zbit) ^ N'(3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // reload wins over any handshake in the same cycle
  always_comb begin
    state_n = state;
    if (restart) begin
      state_n = S_RUN;
    end else begin
      unique case (state)
        S_IDLE: state_n = S_IDLE;
        S_RUN:  if (hs && last) state_n = S_DONE;
        S_DONE: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rk.rk_valid = (state == S_RUN);
    rk.rk_out   = win[0];
    rk.rk_index = count;
    rk.rk_last  = (state == S_RUN) & last;
    busy        = (state == S_RUN);
    done        = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win   <= '0;
      count <= '0;
      zptr  <= '0;
    end else if (restart) begin
      win   <= src;
      count <= '0;
      zptr  <= '0;
    end else if (hs && !last) begin
      for (int j = 0; j < M - 1; j++)
        win[j] <= win[j+1];
      win[M-1] <= nw;
      count    <= count + 7'd1;
      zptr     <= (zptr == 6'd61) ? 6'd0 : zptr + 6'd1;
    end
  end

endmodule

// File: tb/tb_simon_key_scheduler.sv
// Directed bench: SIMON32/64 and SIMON128/256 schedules,
// stalls, abort, async reset and optional replay.
module tb_simon_key_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0]  a_key_in = '0;
  logic         a_key_load = 1'b0;
  logic         a_busy, a_done;
  logic [255:0] b_key_in = '0;
  logic         b_key_load = 1'b0;
  logic         b_busy, b_done;
`ifdef SIMON_KS_REPLAY_EN
  logic a_replay = 1'b0;
  logic b_replay = 1'b0;
`endif

  simon_key_scheduler_if #(.N(16)) a_if ();
  simon_key_scheduler_if #(.N(64)) b_if ();

  simon_key_scheduler #(.N(16), .M(4), .T(32)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (a_key_in),
    .key_load (a_key_load),
`ifdef SIMON_KS_REPLAY_EN
    .rk_replay(a_replay),
`endif
    .busy     (a_busy),
    .done     (a_done),
    .rk       (a_if)
  );

  simon_key_scheduler #(.N(64), .M(4), .T(72)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (b_key_in),
    .key_load (b_key_load),
`ifdef SIMON_KS_REPLAY_EN
    .rk_replay(b_replay),
`endif
    .busy     (b_busy),
    .done     (b_done),
    .rk       (b_if)
  );

  int errs = 0;
  int checks = 0;

  localparam logic [63:0] KA = 64'h1918_1110_0908_0100;
  localparam logic [63:0] KB = 64'h0123_4567_89AB_CDEF;
  localparam logic [255:0] KL =
    256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;

  logic [61:0] z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  logic [61:0] z4 =
    62'b11010001111001101011011000100000010111000011001010010011101111;

  logic [63:0] ea [128];
  logic [63:0] eb [128];
  logic [63:0] el [128];

  function automatic logic [63:0] ror(input logic [63:0] x, input int r,
                                      input int n, input logic [63:0] mk);
    return ((x >> r) | (x << (n - r))) & mk;
  endfunction

  // reference schedule: k[i] built from indexed history, z bit (i-m) mod 62
  task automatic model(input int n, input int m, input int t,
                       input logic [255:0] key, input logic [61:0] z,
                       output logic [63:0] k [128]);
    logic [63:0] mk, tmp;
    int j;
    mk = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < 128; i++) k[i] = '0;
    for (int i = 0; i < m; i++) k[i] = 64'(key >> (n * i)) & mk;
    for (int i = m; i < t; i++) begin
      tmp = ror(k[i-1], 3, n, mk);
      if (m == 4) tmp = tmp ^ k[i-3];
      tmp = tmp ^ ror(tmp, 1, n, mk);
      j = (i - m) % 62;
      k[i] = (~k[i-m] ^ tmp ^ 64'(z[61-j]) ^ 64'd3) & mk;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_if.rk_ready = 1'b0;
    b_if.rk_ready = 1'b0;
    #2;
    checks++;
    if ({a_if.rk_valid, a_if.rk_out, a_if.rk_index, a_if.rk_last,
         a_busy, a_done} !== '0) begin
      errs++;
      $display("FAIL reset_a got=%h want=0",
        {a_if.rk_valid, a_if.rk_out, a_if.rk_index, a_if.rk_last,
         a_busy, a_done});
    end
    checks++;
    if ({b_if.rk_valid, b_if.rk_out, b_if.rk_index, b_if.rk_last,
         b_busy, b_done} !== '0) begin
      errs++;
      $display("FAIL reset_b got=%h want=0",
        {b_if.rk_valid, b_if.rk_out, b_if.rk_index, b_if.rk_last,
         b_busy, b_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] hand [5];
    hand[0] = 16'h0100; hand[1] = 16'h0908; hand[2] = 16'h1110;
    hand[3] = 16'h1918; hand[4] = 16'h71C3;
    a_key_in = KA;
    a_key_load = 1'b1;
    @(negedge clk);
    a_key_load = 1'b0;
    a_if.rk_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (a_if.rk_valid !== 1'b1 || a_busy !== 1'b1) begin
        errs++;
        $display("FAIL basic_valid[%0d] got=%b/%b want=1/1",
          i, a_if.rk_valid, a_busy);
      end
      checks++;
      if (a_if.rk_out !== ((i < 5) ? hand[i] : ea[i][15:0])) begin
        errs++;
        $display("FAIL basic_key[%0d] got=%h want=%h", i, a_if.rk_out,
          (i < 5) ? hand[i] : ea[i][15:0]);
      end
      checks++;
      if (a_if.rk_index !== 7'(i) || a_if.rk_last !== (i == 31)) begin
        errs++;
        $display("FAIL basic_idx[%0d] got=%0d/%b want=%0d/%b",
          i, a_if.rk_index, a_if.rk_last, i, i == 31);
      end
      @(negedge clk);
    end
    checks++;
    if (a_done !== 1'b1 || a_if.rk_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_done got=%b/%b want=1/0", a_done, a_if.rk_valid);
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_if.rk_valid !== 1'b0 || a_busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_idle got=%b%b%b want=000",
        a_done, a_if.rk_valid, a_busy);
    end
  endtask

  task automatic test_stall();
    int i, cyc;
    logic r;
    logic [15:0] prev;
    logic stalled;
    i = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    a_if.rk_ready = 1'b0;
    a_key_in = KA;
    a_key_load = 1'b1;
    @(negedge clk);
    a_key_load = 1'b0;
    while (i < 32 && cyc < 2000) begin
      checks++;
      if (a_if.rk_valid !== 1'b1 || a_if.rk_out !== ea[i][15:0] ||
          a_if.rk_index !== 7'(i)) begin
        errs++;
        $display("FAIL stall_key[%0d] got=%b/%h/%0d want=1/%h/%0d", i,
          a_if.rk_valid, a_if.rk_out, a_if.rk_index, ea[i][15:0], i);
      end
      if (stalled) begin
        checks++;
        if (a_if.rk_out !== prev) begin
          errs++;
          $display("FAIL stall_hold[%0d] got=%h want=%h", i,
            a_if.rk_out, prev);
        end
      end
      r = 1'($urandom_range(0, 1));
      a_if.rk_ready = r;
      prev = a_if.rk_out;
      stalled = ~r;
      @(negedge clk);
      cyc++;
      if (r) i++;
    end
    checks++;
    if (cyc >= 2000) begin
      errs++;
      $display("FAIL stall_timeout got=%0d keys want=32", i);
    end
    checks++;
    if (a_done !== 1'b1) begin
      errs++;
      $display("FAIL stall_done got=%b want=1", a_done);
    end
    a_if.rk_ready = 1'b1;
    @(negedge clk);
  endtask

`ifdef SIMON_KS_REPLAY_EN
  task automatic test_replay();
    a_key_in = '0;
    a_replay = 1'b1;
    @(negedge clk);
    a_replay = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (a_if.rk_valid !== 1'b1 || a_if.rk_out !== ea[i][15:0]) begin
        errs++;
        $display("FAIL replay_key[%0d] got=%b/%h want=1/%h", i,
          a_if.rk_valid, a_if.rk_out, ea[i][15:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (a_done !== 1'b1) begin
      errs++;
      $display("FAIL replay_done got=%b want=1", a_done);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_wide();
    b_key_in = KL;
    b_key_load = 1'b1;
    @(negedge clk);
    b_key_load = 1'b0;
    b_if.rk_ready = 1'b1;
    for (int i = 0; i < 72; i++) begin
      checks++;
      if (b_if.rk_valid !== 1'b1 || b_if.rk_out !== el[i] ||
          b_if.rk_index !== 7'(i) || b_if.rk_last !== (i == 71)) begin
        errs++;
        $display("FAIL wide_key[%0d] got=%b/%h/%0d/%b want=1/%h/%0d/%b",
          i, b_if.rk_valid, b_if.rk_out, b_if.rk_index, b_if.rk_last,
          el[i], i, i == 71);
      end
      @(negedge clk);
    end
    checks++;
    if (b_done !== 1'b1) begin
      errs++;
      $display("FAIL wide_done got=%b want=1", b_done);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    a_if.rk_ready = 1'b1;
    a_key_in = KA;
    a_key_load = 1'b1;
    @(negedge clk);
    a_key_load = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    checks++;
    if (a_if.rk_index !== 7'd10 || a_if.rk_out !== ea[10][15:0]) begin
      errs++;
      $display("FAIL abort_pre got=%0d/%h want=10/%h",
        a_if.rk_index, a_if.rk_out, ea[10][15:0]);
    end
    a_key_in = KB;
    a_key_load = 1'b1;
    @(negedge clk);
    a_key_load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (a_if.rk_valid !== 1'b1 || a_if.rk_out !== eb[i][15:0] ||
          a_if.rk_index !== 7'(i) || a_done !== 1'b0) begin
        errs++;
        $display("FAIL abort_key[%0d] got=%b/%h/%0d/%b want=1/%h/%0d/0",
          i, a_if.rk_valid, a_if.rk_out, a_if.rk_index, a_done,
          eb[i][15:0], i);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    checks++;
    if (a_if.rk_index !== 7'd7) begin
      errs++;
      $display("FAIL rstmid_pre got=%0d want=7", a_if.rk_index);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_if.rk_valid, a_if.rk_out, a_if.rk_index, a_if.rk_last,
         a_busy, a_done} !== '0) begin
      errs++;
      $display("FAIL rstmid_async got=%h want=0",
        {a_if.rk_valid, a_if.rk_out, a_if.rk_index, a_if.rk_last,
         a_busy, a_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (a_if.rk_valid !== 1'b0 || a_done !== 1'b0) begin
        errs++;
        $display("FAIL rstmid_idle[%0d] got=%b/%b want=0/0",
          i, a_if.rk_valid, a_done);
      end
    end
    a_key_in = KB;
    a_key_load = 1'b1;
    @(negedge clk);
    a_key_load = 1'b0;
    checks++;
    if (a_if.rk_valid !== 1'b1 || a_if.rk_out !== eb[0][15:0]) begin
      errs++;
      $display("FAIL rstmid_reload got=%b/%h want=1/%h",
        a_if.rk_valid, a_if.rk_out, eb[0][15:0]);
    end
  endtask

  initial begin
    model(16, 4, 32, 256'(KA), z0, ea);
    model(16, 4, 32, 256'(KB), z0, eb);
    model(64, 4, 72, KL, z4, el);
    test_reset();
    test_basic();
    test_stall();
`ifdef SIMON_KS_REPLAY_EN
    test_replay();
`endif
    test_wide();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
